// File: rtl/qkv_rd_seq.sv
// Row-read sequencer: walks a wrapped range of SRAM rows and streams the
// 1-cycle-latency read data out through a 2-entry skid FIFO with back-pressure.
module qkv_rd_seq #(
    parameter int ROW_COUNT = 64,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 3840
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];

    logic              pop;
    logic [2:0]        occ_after;
    logic              can_issue;
    logic [CNT_W-1:0]  addr_sum;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = out_valid && ((sent_q + CNT_W'(1)) == num_q);
    assign pop       = out_valid && out_ready;

    // A slot freed by this cycle's pop may be reused, which keeps one row per clock
    // under continuous ready while never overrunning the FIFO.
    assign occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign can_issue = (occ_after < 3'd2);
    assign rd_en     = (state_q == RUN) && (issued_q < num_q) && can_issue;

    assign addr_sum  = CNT_W'(base_q) + issued_q;
    assign r_addr    = (addr_sum >= CNT_W'(ROW_COUNT)) ? ADDR_W'(addr_sum - CNT_W'(ROW_COUNT))
                                                       : ADDR_W'(addr_sum);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q;
        sent_d     = sent_q;
        inflight_d = rd_en;
        done_d     = 1'b0;
        count_d    = 2'(occ_after);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;

        if (inflight_q) begin
            mem_d[wr_ptr_q] = rd_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            sent_d   = sent_q + CNT_W'(1);
        end
        if (rd_en) begin
            issued_d = issued_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = num_rows;
                    issued_d = '0;
                    sent_d   = '0;
                    if (num_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (rd_en && ((issued_q + CNT_W'(1)) == num_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_qkv_rd_seq.sv
// Scoreboard bench for qkv_rd_seq: a behavioural SRAM plus a command-level model
// that predicts the address walk, beat stream, busy and done.
module tb_qkv_rd_seq;

    localparam int ROW_COUNT = 64;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 3840;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_rows;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    qkv_rd_seq #(
        .ROW_COUNT(ROW_COUNT),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .num_rows (num_rows),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .r_addr   (r_addr),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] sram [ROW_COUNT];
    logic [DATA_W-1:0] exp_data_q [$];
    bit                exp_last_q [$];
    int                exp_addr_q [$];
    bit                m_active;
    bit                m_done_next;
    int                rd_cnt;
    int                beat_cnt;
    int                n_cmp;
    int                n_fail;
    int                ready_mode;

    // Behavioural SRAM: data for the addressed row appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= sram[r_addr];
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkData(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got low word %h expected low word %h at %0t",
                     name, act[31:0], exp[31:0], $time);
        end
    endtask

    task automatic failNow(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: got event expected none at %0t", name, $time);
    endtask

    // Monitor: compares every cycle against the command-level model.
    always @(negedge clk) begin : monitor
        bit done_new;
        bit act_next;
        int addr;
        int n;
        if (!rst_n) begin
            exp_data_q.delete();
            exp_last_q.delete();
            exp_addr_q.delete();
            m_active    = 1'b0;
            m_done_next = 1'b0;
        end else begin
            done_new = 1'b0;
            act_next = m_active;
            checkOutput("busy", 64'(busy), 64'(m_active));
            checkOutput("done", 64'(done), 64'(m_done_next));
            if (out_valid) begin
                if (exp_data_q.size() == 0) begin
                    failNow("unexpected_beat");
                end else begin
                    checkData("out_data", out_data, exp_data_q[0]);
                    checkOutput("out_last", 64'(out_last), 64'(exp_last_q[0]));
                    if (out_ready) begin
                        beat_cnt++;
                        if (exp_last_q[0]) begin
                            done_new = 1'b1;
                            act_next = 1'b0;
                        end
                        void'(exp_data_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end
            if (rd_en) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) failNow("unexpected_rd_en");
                else checkOutput("r_addr", 64'(r_addr), 64'(exp_addr_q.pop_front()));
            end
            if (start && !m_active) begin
                n = int'(num_rows);
                for (int i = 0; i < n; i++) begin
                    addr = (int'(base_addr) + i) % ROW_COUNT;
                    exp_addr_q.push_back(addr);
                    exp_data_q.push_back(sram[addr]);
                    exp_last_q.push_back(i == n - 1);
                end
                if (n == 0) done_new = 1'b1;
                else act_next = 1'b1;
            end
            m_active    = act_next;
            m_done_next = done_new;
        end
    end

    task automatic applyStimulus(input int b, input int n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        num_rows  = (ADDR_W + 1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (!m_active && !m_done_next && exp_data_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNow("command_timeout");
        repeat (2) @(posedge clk);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_rd_en", 64'(rd_en), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_r_addr", 64'(r_addr), 64'd0);
        checkData("rst_out_data", out_data, '0);
    endtask

    initial begin
        int r0;
        int b0;
        n_cmp      = 0;
        n_fail     = 0;
        rd_cnt     = 0;
        beat_cnt   = 0;
        ready_mode = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_rows   = '0;
        for (int a = 0; a < ROW_COUNT; a++) begin
            for (int w = 0; w < DATA_W / 32; w++) begin
                sram[a][w*32 +: 32] = $urandom();
            end
        end
        #3;
        checkResetOutputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Test 1: full-rate read of rows 5..8
        ready_mode = 0;
        applyStimulus(5, 4);
        r0 = rd_cnt;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t1_rd_burst", 64'(rd_cnt - r0), 64'd4);
        waitIdle(100);

        // Test 2: address wrap
        applyStimulus(62, 4);
        waitIdle(100);

        // Test 3: stalled consumer
        ready_mode = 1;
        b0 = beat_cnt;
        applyStimulus(20, 3);
        r0 = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t3_rd_stalled", 64'(rd_cnt - r0), 64'd2);
        checkOutput("t3_beats_stalled", 64'(beat_cnt - b0), 64'd0);
        ready_mode = 0;
        waitIdle(100);
        checkOutput("t3_beats", 64'(beat_cnt - b0), 64'd3);

        // Test 4: empty command
        r0 = rd_cnt;
        b0 = beat_cnt;
        applyStimulus(7, 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t4_rd", 64'(rd_cnt - r0), 64'd0);
        checkOutput("t4_beats", 64'(beat_cnt - b0), 64'd0);

        // Test 5: re-start while busy, then reset mid-stream
        ready_mode = 2;
        applyStimulus(30, 20);
        repeat (3) @(posedge clk);
        applyStimulus(0, 5);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs();
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        applyStimulus(40, 6);
        waitIdle(100);

        // Test 6: whole array with random back-pressure
        ready_mode = 2;
        b0 = beat_cnt;
        applyStimulus(10, 64);
        waitIdle(2000);
        checkOutput("t6_beats", 64'(beat_cnt - b0), 64'd64);

        // Random commands
        for (int k = 0; k < 8; k++) begin
            ready_mode = int'($urandom_range(0, 2));
            if (ready_mode == 1) ready_mode = 2;
            applyStimulus(int'($urandom_range(0, ROW_COUNT - 1)), int'($urandom_range(0, ROW_COUNT)));
            waitIdle(2000);
        end

        checkOutput("final_queue_empty", 64'(exp_data_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/qkv_rd_seq.md
QKV_RD_SEQ -- requirements
Module: qkv_rd_seq

Interface
REQ-001 Parameters SHALL be: ROW_COUNT, default 64, number of SRAM rows; ADDR_W, default 6, SRAM address width, equal to clog2(ROW_COUNT); DATA_W, default 3840, SRAM read-data width (48 lanes x 80 bits).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse.
- base_addr  in  ADDR_W  first row to read, sampled on accepted start.
- num_rows  in  ADDR_W+1  rows to read, 0..ROW_COUNT, sampled on accepted start.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- rd_en  out  1  SRAM read enable.
- r_addr  out  ADDR_W  SRAM read address, broadcast to all lanes.
- rd_data  in  DATA_W  SRAM read data, valid exactly one cycle after rd_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  stream payload.
- out_last  out  1  marks the final row of the command.

Function
REQ-004 The block SHALL implement the states IDLE, RUN and DRAIN.
REQ-005 In IDLE, start SHALL be accepted; base_addr and num_rows SHALL be latched; the next state SHALL be RUN, or IDLE with a done pulse on the next cycle when num_rows==0.
REQ-006 start SHALL be ignored while busy is high; busy SHALL be high in RUN and DRAIN.
REQ-007 In RUN, the block SHALL assert rd_en for one cycle per row, with r_addr = (base_addr + issued_count) mod ROW_COUNT, so addresses wrap from ROW_COUNT-1 to 0.
REQ-008 The block SHALL capture rd_data into an internal 2-entry FIFO in the cycle after each rd_en; SRAM read latency is exactly 1 cycle.
REQ-009 A read SHALL issue only when (FIFO occupancy + reads in flight) < 2, so no returned row is ever dropped under back-pressure.
REQ-010 When out_ready is held high continuously, rd_en SHALL be asserted every cycle, giving a throughput of one row per clock.
REQ-011 When the last read has issued, the state SHALL move to DRAIN; rd_en SHALL be low in DRAIN and IDLE.
REQ-012 out_valid SHALL be high whenever the FIFO is non-empty, and out_data SHALL be the FIFO head.
REQ-013 A beat SHALL transfer when out_valid and out_ready are both high; out_data and out_last SHALL stay stable while out_valid is high and out_ready is low.
REQ-014 out_last SHALL be high only on the beat carrying row num_rows-1 of the command.
REQ-015 done SHALL pulse in the cycle after the out_last beat transfers, and the state SHALL return to IDLE in that same cycle.
REQ-016 A FIFO write and a FIFO read in the same cycle SHALL leave occupancy unchanged.
REQ-017 When num_rows==ROW_COUNT, every row SHALL be read exactly once, in wrapped order starting at base_addr.
REQ-018 Counters SHALL be ADDR_W+1 bits wide and SHALL NOT overflow for num_rows==ROW_COUNT.

Reset
REQ-019 While rst_n is low, the following SHALL hold immediately, without waiting for a clock edge:
- state = IDLE.
- busy, done, rd_en, out_valid and out_last = 0.
- r_addr and out_data = 0.
- FIFO empty; all counters 0.
REQ-020 Reset asserted mid-command SHALL abort the command, discard buffered and in-flight data, and produce no done pulse.

Verification
REQ-021 Test 1: base_addr=5, num_rows=4, out_ready=1 -> rd_en for 4 consecutive cycles with r_addr 5,6,7,8; beats one cycle later; out_last on row 8; done one cycle after that beat.
REQ-022 Test 2: base_addr=62, num_rows=4 -> r_addr sequence 62,63,0,1.
REQ-023 Test 3: num_rows=3, out_ready=0 for 10 cycles, then 1 -> exactly 2 rd_en pulses before release; all 3 rows delivered in order with no data loss; payloads stable while stalled.
REQ-024 Test 4: num_rows=0 -> no rd_en, no out_valid, done pulse on the cycle after start.
REQ-025 Test 5: start re-pulsed while busy, then rst_n pulsed low mid-stream -> second start ignored; all outputs 0 during reset; no done pulse; a new command runs normally afterwards.
REQ-026 Test 6: num_rows=64, base_addr=10, random out_ready -> 64 beats covering rows 10..63 then 0..9, each exactly once.
